// File: rtl/cam_init_sequencer.sv
// -----------------------------------------------------------------------------
// cam_init_sequencer
//
// Power-up and register-load sequencer for the camera sensor. On start it
// releases sensor power-down, holds the sensor in reset for RST_MS ticks,
// waits SETTLE_MS ticks, then walks a configuration ROM issuing one SCCB
// register write per entry. ROM word 16'hFFFF ends the table and 16'hF0nn
// inserts an nn-tick pause. Completion is flagged on done_o.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   tick_ms_i    1 ms strobe from the clock divider (one cycle wide)
//   start_i      launches the sequence (ignored while busy_o)
//   rom_addr_o   configuration ROM address (registered)
//   rom_data_i   ROM word {reg_addr, reg_val}, combinational from rom_addr_o
//   wr_valid_o   write request to the SCCB master
//   wr_addr_o    sensor register address, stable while wr_valid_o
//   wr_data_o    sensor register value, stable while wr_valid_o
//   wr_ready_i   SCCB master accepts the request
//   cam_pwdn_o   sensor power-down, active-high
//   cam_rst_n_o  sensor reset, active-low
//   busy_o       sequence in progress
//   done_o       all entries loaded; held until next start or reset
// -----------------------------------------------------------------------------
module cam_init_sequencer #(
    parameter int RST_MS    = 10,
    parameter int SETTLE_MS = 20,
    parameter int ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_ms_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              wr_valid_o,
    output logic [7:0]        wr_addr_o,
    output logic [7:0]        wr_data_o,
    input  logic              wr_ready_i,
    output logic              cam_pwdn_o,
    output logic              cam_rst_n_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_SETTLE,
        S_FETCH,
        S_WRITE,
        S_DELAY,
        S_FIN
    } state_t;

    localparam logic [15:0]       RST_T     = 16'(RST_MS);
    localparam logic [15:0]       SETTLE_T  = 16'(SETTLE_MS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t state_q, state_d;

    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        dly_q, dly_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              pwdn_q, pwdn_d;
    logic              rstn_q, rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [15:0] target;
    logic        counting;
    logic        cnt_hit;
    logic        is_end;
    logic        is_dly;
    logic        accept;
    logic        last_entry;

    assign is_end     = (rom_data_i == 16'hFFFF);
    assign is_dly     = (rom_data_i[15:8] == 8'hF0);
    assign accept     = wr_valid_q & wr_ready_i;
    assign last_entry = (rom_addr_q == ADDR_LAST);

    // Tick target for whichever timed state is active.
    always_comb begin
        target   = 16'd0;
        counting = 1'b0;
        case (state_q)
            S_PWRUP:  begin target = RST_T;          counting = 1'b1; end
            S_SETTLE: begin target = SETTLE_T;       counting = 1'b1; end
            S_DELAY:  begin target = {8'h00, dly_q}; counting = 1'b1; end
            default:  begin target = 16'd0;          counting = 1'b0; end
        endcase
    end

    // A zero target exits after one cycle; otherwise exit on the edge that
    // samples the Nth tick.
    assign cnt_hit = (target == 16'd0) || (tick_ms_i && ((cnt_q + 16'd1) == target));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_PWRUP;
            end
            S_PWRUP: begin
                if (cnt_hit) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_hit) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (is_end)      state_d = S_FIN;
                else if (is_dly) state_d = S_DELAY;
                else             state_d = S_WRITE;
            end
            S_WRITE: begin
                if (accept) state_d = last_entry ? S_FIN : S_FETCH;
            end
            S_DELAY: begin
                if (cnt_hit) state_d = last_entry ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        rom_addr_d = rom_addr_q;
        dly_d      = dly_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pwdn_d     = pwdn_q;
        rstn_d     = rstn_q;
        busy_d     = busy_q;
        done_d     = done_q;

        // Counter clears outside timed states and on every exit from one.
        cnt_d = 16'd0;
        if (counting && !cnt_hit) begin
            cnt_d = tick_ms_i ? (cnt_q + 16'd1) : cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pwdn_d     = 1'b0;
                    rstn_d     = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    rom_addr_d = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_hit) rstn_d = 1'b1;
            end
            S_SETTLE: begin
                if (cnt_hit) rom_addr_d = '0;
            end
            S_FETCH: begin
                if (is_end) begin
                    dly_d = dly_q;
                end else if (is_dly) begin
                    dly_d = rom_data_i[7:0];
                end else begin
                    wr_addr_d  = rom_data_i[15:8];
                    wr_data_d  = rom_data_i[7:0];
                    wr_valid_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    wr_valid_d = 1'b0;
                    // Natural wrap takes the address back to 0 after the last entry.
                    rom_addr_d = rom_addr_q + 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_hit) rom_addr_d = rom_addr_q + 1'b1;
            end
            S_FIN: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = busy_q;
            end
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= 16'd0;
            dly_q      <= 8'd0;
            rom_addr_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            pwdn_q     <= 1'b1;
            rstn_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            rom_addr_q <= rom_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            pwdn_q     <= pwdn_d;
            rstn_q     <= rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign cam_pwdn_o  = pwdn_q;
    assign cam_rst_n_o = rstn_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cam_init_sequencer
//
// Directed bench for cam_init_sequencer with RST_MS=2, SETTLE_MS=3, ADDR_W=2.
// The ROM is a 4-entry array read combinationally from rom_addr.
// -----------------------------------------------------------------------------
module tb_cam_init_sequencer;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        tick_ms  = 1'b0;
    logic        start    = 1'b0;
    logic        wr_ready = 1'b1;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cam_pwdn;
    logic        cam_rst_n;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    cam_init_sequencer #(
        .RST_MS   (2),
        .SETTLE_MS(3),
        .ADDR_W   (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_ms_i  (tick_ms),
        .start_i    (start),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .wr_ready_i (wr_ready),
        .cam_pwdn_o (cam_pwdn),
        .cam_rst_n_o(cam_rst_n),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pwdn"},     cam_pwdn,  1);
        check({tag, "_rst_n"},    cam_rst_n, 0);
        check({tag, "_wr_valid"}, wr_valid,  0);
        check({tag, "_wr_addr"},  wr_addr,   0);
        check({tag, "_wr_data"},  wr_data,   0);
        check({tag, "_rom_addr"}, rom_addr,  0);
        check({tag, "_busy"},     busy,      0);
        check({tag, "_done"},     done,      0);
    endtask

    // Start, 2 power-up ticks, 3 settle ticks: DUT is then in FETCH.
    task automatic run_to_fetch();
        pulse_start();
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nw;
        logic [15:0] last_wr;

        // ---------------- power-on reset and idle ----------------
        rom = '{16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF};
        repeat (3) step();
        rst = 1'b0;
        step();
        check_reset("por");
        repeat (3) tick();
        check_reset("idle_ticks");

        // ---------------- full sequence ----------------
        pulse_start();
        check("fs_busy_k1",  busy,      1);
        check("fs_pwdn_k1",  cam_pwdn,  0);
        check("fs_rstn_k1",  cam_rst_n, 0);
        tick();
        check("fs_rstn_tick1", cam_rst_n, 0);
        tick();
        check("fs_rstn_tick2", cam_rst_n, 1);
        repeat (4) step();
        check("fs_no_tick_valid", wr_valid, 0);
        tick();
        tick();
        check("fs_settle2_valid", wr_valid, 0);
        tick();
        check("fs_fetch_valid", wr_valid, 0);
        step();
        check("fs_w1_valid", wr_valid, 1);
        check("fs_w1_addr",  wr_addr,  8'h12);
        check("fs_w1_data",  wr_data,  8'h34);
        check("fs_w1_rom",   rom_addr, 0);
        step();
        check("fs_w1_pulse", wr_valid, 0);
        check("fs_rom1",     rom_addr, 1);
        step();
        check("fs_w2_valid", wr_valid, 1);
        check("fs_w2_addr",  wr_addr,  8'h56);
        check("fs_w2_data",  wr_data,  8'h78);
        step();
        check("fs_w2_pulse", wr_valid, 0);
        check("fs_rom2",     rom_addr, 2);
        step();
        check("fs_fin_done", done, 0);
        check("fs_fin_busy", busy, 1);
        step();
        check("fs_done",      done,      1);
        check("fs_busy_end",  busy,      0);
        check("fs_pwdn_kept", cam_pwdn,  0);
        check("fs_rstn_kept", cam_rst_n, 1);
        repeat (2) tick();
        check("fs_done_hold", done, 1);

        // ---------------- mid-simulation reset ----------------
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        step();
        rst = 1'b0;
        step();
        tick();
        tick();
        check_reset("post_rst_ticks");

        // ---------------- backpressure ----------------
        rom = '{16'hABCD, 16'h1357, 16'hFFFF, 16'hFFFF};
        wr_ready = 1'b0;
        run_to_fetch();
        check("bp_fetch_valid", wr_valid, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            wr_ready = (i == 5);
            check($sformatf("bp_valid_%0d", i), wr_valid, 1);
            check($sformatf("bp_addr_%0d", i),  wr_addr,  8'hAB);
            check($sformatf("bp_data_%0d", i),  wr_data,  8'hCD);
            check($sformatf("bp_rom_%0d", i),   rom_addr, 0);
            step();
        end
        check("bp_accept_valid", wr_valid, 0);
        check("bp_accept_rom",   rom_addr, 1);
        step();
        check("bp_w2_valid", wr_valid, 1);
        check("bp_w2_addr",  wr_addr,  8'h13);
        check("bp_w2_data",  wr_data,  8'h57);
        step();
        check("bp_w2_rom", rom_addr, 2);
        step();
        step();
        check("bp_done", done, 1);
        check("bp_rom_end", rom_addr, 2);

        // ---------------- delay markers, restart after done ----------------
        rom = '{16'hF005, 16'hAA55, 16'hF000, 16'hFFFF};
        pulse_start();
        check("rs_done_clr", done,      0);
        check("rs_busy",     busy,      1);
        check("rs_rom0",     rom_addr,  0);
        check("rs_rstn_low", cam_rst_n, 0);
        repeat (5) tick();
        step();
        repeat (3) step();
        check("dl_wait_valid", wr_valid, 0);
        check("dl_wait_rom",   rom_addr, 0);
        repeat (4) tick();
        check("dl_tick4_rom",   rom_addr, 0);
        check("dl_tick4_valid", wr_valid, 0);
        tick();
        check("dl_tick5_rom",   rom_addr, 1);
        check("dl_tick5_valid", wr_valid, 0);
        step();
        check("dl_w_valid", wr_valid, 1);
        check("dl_w_addr",  wr_addr,  8'hAA);
        check("dl_w_data",  wr_data,  8'h55);
        step();
        check("dl_rom2", rom_addr, 2);
        step();
        check("dl_zero_in", rom_addr, 2);
        step();
        check("dl_zero_out", rom_addr, 3);
        check("dl_zero_valid", wr_valid, 0);
        step();
        check("dl_fin_done", done, 0);
        step();
        check("dl_done", done, 1);

        // ---------------- start in SETTLE ignored, reset in WRITE ----------------
        rom = '{16'h9ABC, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        wr_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        pulse_start();
        check("ab_busy",  busy,      1);
        check("ab_rstn",  cam_rst_n, 1);
        check("ab_pwdn",  cam_pwdn,  0);
        check("ab_done",  done,      0);
        repeat (3) tick();
        step();
        check("ab_w_valid", wr_valid, 1);
        check("ab_w_addr",  wr_addr,  8'h9A);
        step();
        check("ab_w_hold", wr_valid, 1);
        rst = 1'b1;
        #1;
        check_reset("ab_rst");
        step();
        rst = 1'b0;
        wr_ready = 1'b1;
        step();

        // ---------------- ROM exhaustion ----------------
        rom = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_to_fetch();
        nw = 0;
        last_wr = 16'h0000;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (wr_valid) begin
                nw++;
                last_wr = {wr_addr, wr_data};
            end
        end
        check("ex_writes",   nw,       4);
        check("ex_last_wr",  last_wr,  16'h4444);
        check("ex_done",     done,     1);
        check("ex_busy",     busy,     0);
        check("ex_rom_wrap", rom_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_init_sequencer.md
# cam_init_sequencer

Power-up and register-load sequencer for the camera sensor. After `start`, it:
- drives the sensor power-down and reset pins through timed phases, counted in millisecond ticks from the free-running clock divider;
- walks an external configuration ROM and issues one register write per entry to the SCCB master over a valid/ready handshake;
- honours delay markers in the ROM;
- flags completion to the capture pipeline.

## Interface
Parameters:
- `RST_MS`, 10: ticks that `cam_rst_n` is held low after power-down is released.
- `SETTLE_MS`, 20: ticks to wait after `cam_rst_n` is released, before the first ROM fetch.
- `ADDR_W`, 8: ROM address width; the ROM holds up to 2^ADDR_W entries.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_ms`  in  1  one-cycle pulse every 1 ms, from the clock divider.
- `start`  in  1  one-cycle pulse that launches the sequence.
- `rom_addr`  out  ADDR_W  configuration ROM address (registered).
- `rom_data`  in  16  ROM word for `rom_addr`, read combinationally. Format is {reg_addr[15:8], reg_val[7:0]}.
- `wr_valid`  out  1  write request to the SCCB master.
- `wr_addr`  out  8  sensor register address; stable while `wr_valid` is high.
- `wr_data`  out  8  sensor register value; stable while `wr_valid` is high.
- `wr_ready`  in  1  SCCB master accepts the request.
- `cam_pwdn`  out  1  sensor power-down pin, active-high.
- `cam_rst_n`  out  1  sensor reset pin, active-low.
- `busy`  out  1  high from the cycle after an accepted `start` until the sequence ends.
- `done`  out  1  high once all entries are loaded; stays high until the next `start` or `rst`.

## Operation
- Reset values:
  - state IDLE
  - `cam_pwdn`=1, `cam_rst_n`=0
  - `wr_valid`=0, `wr_addr`=0, `wr_data`=0
  - `rom_addr`=0
  - `busy`=0, `done`=0
  - tick counter 0
- ROM word codes:
  - 16'hFFFF: end of table.
  - 16'hF0nn: delay of nn ms; no write is issued.
  - Any other value: register write.
- States and transitions:
  - IDLE: `start` goes to PWRUP. In PWRUP, `cam_pwdn`=0, `cam_rst_n`=0, tick counter cleared.
  - PWRUP: counts `tick_ms` pulses. On the cycle the count reaches RST_MS, go to SETTLE with `cam_rst_n`=1 and the counter cleared.
  - SETTLE: on reaching SETTLE_MS ticks, go to FETCH with `rom_addr`=0.
  - FETCH (1 cycle): decode `rom_data`.
    - End marker: go to FIN.
    - Delay marker: go to DELAY with the count target set to nn.
    - Otherwise: latch `wr_addr`/`wr_data`, set `wr_valid`=1, go to WRITE.
  - WRITE: hold all outputs. On a cycle with `wr_valid`&`wr_ready`, clear `wr_valid`, increment `rom_addr`, go to FETCH.
  - DELAY: on reaching nn ticks, increment `rom_addr` and go to FETCH.
  - FIN: `busy`=0, `done`=1; return to IDLE.
- Tick counting:
  - A count of N ticks ends on the clock edge that samples the Nth `tick_ms` pulse.
  - N=0 (parameter or delay field) exits after exactly one cycle in the state, without waiting for a tick.
  - Ticks that arrive in other states are ignored.
- ROM exhaustion: if `rom_addr` would wrap past 2^ADDR_W−1 after a write or delay, go to FIN instead. `rom_addr` then wraps to 0.
- `start` handling:
  - Ignored while `busy`=1.
  - `start` while `done`=1 clears `done` and reruns the full sequence from PWRUP.
- Reset mid-operation: every output returns to its reset value immediately. This includes dropping `wr_valid`; the SCCB master must tolerate an abandoned request.
- `cam_pwdn` and `cam_rst_n` keep their last values in FIN and IDLE (sensor stays powered). Only `rst` re-asserts them.

## Timing
- `start` sampled at edge k: `busy`=1 and `cam_pwdn`=0 at k+1.
- From entering FETCH to `wr_valid`=1: 1 cycle.
- Minimum cost per write entry: 2 cycles (FETCH plus WRITE with `wr_ready` already high).
- Delay entry: 1 FETCH cycle plus nn ticks.
- End marker: FETCH at cycle t, FIN at t+1, `done`=1 and `busy`=0 visible from t+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle: assert `rst` mid-simulation.
  - Required: reset values above on the same cycle. Then `tick_ms` pulses with no `start` leave all outputs unchanged.
- Full sequence: RST_MS=2, SETTLE_MS=3, ROM {1234, 5678, FFFF}, `wr_ready` tied 1.
  - Required: `cam_rst_n` rises on the 2nd tick; first `wr_valid` follows the 3rd subsequent tick.
  - Writes are (12,34) then (56,78), each `wr_valid` pulse 1 cycle long.
  - `done`=1 two cycles after the FFFF fetch.
- Backpressure: `wr_ready` held low for 5 cycles on the first write.
  - Required: `wr_valid`, `wr_addr` and `wr_data` stable for 6 cycles; `rom_addr` increments only after acceptance.
- Delay markers: ROM {F005, AA55, F000, FFFF}.
  - Required: write (AA,55) starts only after 5 ticks; the F000 entry costs 1 cycle with no tick wait.
- Abort and restart:
  - `rst` during WRITE: `wr_valid` drops immediately.
  - `start` during SETTLE: ignored.
  - `start` after `done`: `done` clears and `rom_addr` restarts at 0.
- ROM exhaustion: ADDR_W=2, ROM with no end marker.
  - Required: 4 writes, then `done`=1, and `rom_addr` wraps to 0.
